led_breather: RTL and testbench
===============================

// Module: led_breather
// PURPOSE
//  Downstream LED driver fed by the system-clock domain (sysClk, 100 MHz from the PLL/BUFG).
//  Converts a mode select and a 1-cycle tick from the upstream divider counter into a PWM LED output.
//  Modes: off, full on, breathing (triangular brightness ramp with square-law gamma), tick-driven blink.
//  The duty cycle is latched only at PWM frame boundaries, so the LED never glitches mid-frame.
// PARAMETERS
//  PWM_BITS  8        PWM counter width; frame = 2**PWM_BITS clocks; brightness level range 0..2**PWM_BITS-1
//  STEP_DIV  195312   sysClk cycles per breathing level step (~1 s full up/down cycle at 100 MHz, 8 bits)
// PORTS
//  sysClk  in   1           system clock; the only clock
//  rst     in   1           reset: synchronous, active-high
//  mode    in   2           00=off, 01=on, 10=breathe, 11=blink; sampled every cycle
//  tick    in   1           1-cycle strobe from upstream counter; used only in blink mode
//  led     out  1           registered PWM output, active-high
//  level   out  PWM_BITS    current breathing level (registered)
//  dirUp   out  1           breathing direction: 1=ramping up, 0=ramping down
// BEHAVIOUR
//  Reset (rst=1 at a sysClk edge):
//   - led=0, level=0, dirUp=1.
//   - pwmCnt=0, duty=0, stepCnt=0, blinkOn=0.
//  PWM generation:
//   - pwmCnt (PWM_BITS wide) increments every clock and wraps 2**PWM_BITS-1 -> 0.
//   - duty is PWM_BITS+1 wide; led <= (pwmCnt < duty), so a 1-cycle output latency.
//   - duty <= dutyNext only in the cycle where pwmCnt == 2**PWM_BITS-1; new duty applies from the next frame.
//  dutyNext by mode:
//   - 00 off: 0 (LED constantly low).
//   - 01 on: 2**PWM_BITS (LED constantly high).
//   - 10 breathe: (level*level) >> PWM_BITS, with a 2*PWM_BITS-bit product, zero-extended;
//     level=255 -> 254, level=16 -> 1, level=15 -> 0.
//   - 11 blink: blinkOn ? 2**PWM_BITS : 0.
//  Breathe FSM: states UP (dirUp=1) and DOWN (dirUp=0); it advances only while mode==10.
//   - stepCnt counts 0..STEP_DIV-1; step strobe when stepCnt==STEP_DIV-1, then stepCnt wraps to 0.
//   - On a step in UP: level==MAX -> go to DOWN, level<=MAX-1; otherwise level<=level+1.
//   - On a step in DOWN: level==0 -> go to UP, level<=1; otherwise level<=level-1.
//   - Extremes are therefore held for exactly one step; there is no wrap-around of level.
//  Mode-entry rule: in any cycle where mode!=10, set level<=0, dirUp<=1, stepCnt<=0.
//   - Every entry into breathe starts from dark, ramping up.
//  Blink:
//   - blinkOn toggles on each cycle with tick=1 while mode==11.
//   - blinkOn is cleared in any cycle with mode!=11; ticks in other modes are ignored.
//  Simultaneous events:
//   - rst overrides all.
//   - A mode change on the same edge as the frame-end duty latch uses the new mode's dutyNext.
//   - In blink, a tick on the frame-end cycle latches duty from the pre-toggle blinkOn.
//  Reset mid-frame: takes effect at the next edge; led=0 from then on, and a fresh frame starts at pwmCnt=0.
// TESTING
//  1. rst=1 for 3 cycles, then mode=00 -> led, level stay 0 and dirUp=1 for 1000 cycles.
//  2. mode=01 after reset -> led=1 from the first frame boundary plus 1 cycle, and stays 1 continuously.
//  3. mode=10, STEP_DIV=4, PWM_BITS=4 -> level 0,1..15,14..0,1 on steps every 4 cycles;
//     dirUp falls at the step after level=15.
//  4. Breathe, PWM_BITS=4, level forced to 15 -> duty=14, led high for 14 of every 16 cycles;
//     check duty changes only at pwmCnt=15.
//  5. mode=11, pulse tick every 100 cycles, PWM_BITS=4 -> led toggles full-on/off,
//     each change aligned to the next frame boundary.
//  6. Breathe at level=7, then mode=01 for 1 cycle, then back to 10 -> level=0, dirUp=1, stepCnt restarted;
//     assert rst mid-frame -> led=0 on the next edge.

Source files
------------

// File: rtl/led_breather.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_breather : mode-selected PWM LED driver (off / on / breathe / blink)   |
// | Revision     : 1.0                                                         |
// +--------------------------------------------------------------------------+
module led_breather #(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 195312
) (
   input  logic                sysClk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic                tick,
   output logic                led,
   output logic [PWM_BITS-1:0] level,
   output logic                dirUp
);

   localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PWM_BITS-1:0] c_level_max = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] c_level_one = {{(PWM_BITS-1){1'b0}}, 1'b1};
   localparam logic [PWM_BITS:0]   c_duty_full = {1'b1, {PWM_BITS{1'b0}}};
   localparam logic [PWM_BITS:0]   c_duty_zero = '0;
   localparam logic [STEP_W-1:0]   c_step_last = STEP_W'(STEP_DIV - 1);
   localparam logic [STEP_W-1:0]   c_step_one  = STEP_W'(1);

   localparam logic [1:0] c_mode_off     = 2'b00;
   localparam logic [1:0] c_mode_on      = 2'b01;
   localparam logic [1:0] c_mode_breathe = 2'b10;
   localparam logic [1:0] c_mode_blink   = 2'b11;

   typedef enum logic [0:0] {
      ST_UP   = 1'b0,
      ST_DOWN = 1'b1
   } breathe_state_e;

   breathe_state_e        state_q,    state_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q,  pwm_cnt_d;
   logic [PWM_BITS:0]     duty_q,     duty_d;
   logic                  led_q,      led_d;
   logic [PWM_BITS-1:0]   level_q,    level_d;
   logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
   logic                  blink_on_q, blink_on_d;

   logic                  w_breathe;
   logic                  w_blink;
   logic                  w_step;
   logic                  w_frame_end;
   logic [2*PWM_BITS-1:0] w_level_sq;
   logic [PWM_BITS:0]     w_duty_next;

   assign w_breathe   = (mode == c_mode_breathe);
   assign w_blink     = (mode == c_mode_blink);
   assign w_step      = w_breathe && (step_cnt_q == c_step_last);
   assign w_frame_end = (pwm_cnt_q == c_level_max);

   // Square-law gamma: the top half of the full-width product keeps low levels dim.
   assign w_level_sq  = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};

   always_comb begin
      w_duty_next = c_duty_zero;
      case (mode)
         c_mode_off:     w_duty_next = c_duty_zero;
         c_mode_on:      w_duty_next = c_duty_full;
         c_mode_breathe: w_duty_next = {1'b0, w_level_sq[2*PWM_BITS-1:PWM_BITS]};
         c_mode_blink:   w_duty_next = blink_on_q ? c_duty_full : c_duty_zero;
         default:        w_duty_next = c_duty_zero;
      endcase
   end

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + c_level_one;
      duty_d    = w_frame_end ? w_duty_next : duty_q;
      led_d     = ({1'b0, pwm_cnt_q} < duty_q);
   end

   // Any cycle outside breathe rearms the ramp so each entry starts dark and rising.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      step_cnt_d = step_cnt_q;
      if (!w_breathe) begin
         state_d    = ST_UP;
         level_d    = '0;
         step_cnt_d = '0;
      end else begin
         step_cnt_d = w_step ? '0 : (step_cnt_q + c_step_one);
         if (w_step) begin
            case (state_q)
               ST_UP: begin
                  if (level_q == c_level_max) begin
                     state_d = ST_DOWN;
                     level_d = c_level_max - c_level_one;
                  end else begin
                     level_d = level_q + c_level_one;
                  end
               end
               ST_DOWN: begin
                  if (level_q == '0) begin
                     state_d = ST_UP;
                     level_d = c_level_one;
                  end else begin
                     level_d = level_q - c_level_one;
                  end
               end
               default: begin
                  state_d = ST_UP;
                  level_d = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      blink_on_d = w_blink ? (blink_on_q ^ tick) : 1'b0;
   end

   always_ff @(posedge sysClk) begin
      if (rst) begin
         state_q    <= ST_UP;
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
         led_q      <= 1'b0;
         level_q    <= '0;
         step_cnt_q <= '0;
         blink_on_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
         led_q      <= led_d;
         level_q    <= level_d;
         step_cnt_q <= step_cnt_d;
         blink_on_q <= blink_on_d;
      end
   end

   assign led   = led_q;
   assign level = level_q;
   assign dirUp = (state_q == ST_UP);

endmodule
`default_nettype wire

// File: tb/tb_led_breather.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_breather : randomized self-checking bench for led_breather          |
// | Revision        : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_led_breather;

   localparam int PB    = 4;
   localparam int SD    = 4;
   localparam int FRAME = 1 << PB;
   localparam int LMAX  = FRAME - 1;

   logic          sysClk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic          tick;
   logic          led;
   logic [PB-1:0] level;
   logic          dirUp;

   int total = 0;
   int bad   = 0;

   // Reference model: frame position, latched duty, breathe cycles since entry, blink parity.
   int            m_pos, m_duty, m_bcyc;
   bit            m_blink;
   logic          e_led;
   logic [PB-1:0] e_level;
   logic          e_dir;

   led_breather #(.PWM_BITS(PB), .STEP_DIV(SD)) u_dut (
      .sysClk (sysClk),
      .rst    (rst),
      .mode   (mode),
      .tick   (tick),
      .led    (led),
      .level  (level),
      .dirUp  (dirUp)
   );

   always #5 sysClk = ~sysClk;

   // Breathing level after k steps: triangle 0,1..MAX,MAX-1..1,0,1.. with period 2*MAX.
   function automatic int tri_lvl(input int k);
      int p;
      p = k % (2 * LMAX);
      return (p <= LMAX) ? p : (2 * LMAX - p);
   endfunction

   function automatic bit tri_dir(input int k);
      int p;
      p = k % (2 * LMAX);
      if (k == 0) return 1'b1;
      return (p >= 1) && (p <= LMAX);
   endfunction

   task automatic step(input logic [1:0] md, input bit tk, input bit rs);
      int lvl;
      mode = md;
      tick = tk;
      rst  = rs;
      if (rs) begin
         e_led   = 1'b0;
         m_pos   = 0;
         m_duty  = 0;
         m_bcyc  = 0;
         m_blink = 1'b0;
      end else begin
         e_led = (m_pos < m_duty);
         if (m_pos == FRAME - 1) begin
            lvl = tri_lvl(m_bcyc / SD);
            case (md)
               2'b00:   m_duty = 0;
               2'b01:   m_duty = FRAME;
               2'b10:   m_duty = (lvl * lvl) / FRAME;
               default: m_duty = m_blink ? FRAME : 0;
            endcase
         end
         m_pos   = (m_pos + 1) % FRAME;
         m_bcyc  = (md == 2'b10) ? m_bcyc + 1 : 0;
         m_blink = (md == 2'b11) ? (m_blink ^ tk) : 1'b0;
      end
      e_level = PB'(tri_lvl(m_bcyc / SD));
      e_dir   = tri_dir(m_bcyc / SD);
      @(posedge sysClk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         step(2'b00, 1'b0, 1'b1);
         total++;
         if ({led, level, dirUp} !== {1'b0, PB'(0), 1'b1}) begin
            bad++;
            $display("FAIL reset led/level/dir got=%b/%0d/%b want=0/0/1", led, level, dirUp);
         end
      end
      for (int i = 0; i < 1000; i++) begin
         step(2'b00, 1'($urandom_range(0, 1)), 1'b0);
         total++;
         if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
            bad++;
            $display("FAIL off_idle cyc=%0d got=%b/%0d/%b want=%b/%0d/%b",
                     i, led, level, dirUp, e_led, e_level, e_dir);
         end
      end
   endtask

   task automatic test_on;
      int first_hi;
      first_hi = -1;
      step(2'b00, 1'b0, 1'b1);
      for (int i = 1; i <= 80; i++) begin
         step(2'b01, 1'b0, 1'b0);
         if (led === 1'b1 && first_hi < 0) first_hi = i;
         total++;
         if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
            bad++;
            $display("FAIL on_mode cyc=%0d got=%b/%0d/%b want=%b/%0d/%b",
                     i, led, level, dirUp, e_led, e_level, e_dir);
         end
      end
      total++;
      if (first_hi !== FRAME + 1) begin
         bad++;
         $display("FAIL on_first_high got=%0d want=%0d", first_hi, FRAME + 1);
      end
   endtask

   task automatic test_breathe;
      int fall_at;
      logic prev_dir;
      fall_at  = -1;
      prev_dir = 1'b1;
      step(2'b00, 1'b0, 1'b1);
      for (int i = 1; i <= 260; i++) begin
         step(2'b10, 1'b0, 1'b0);
         if (prev_dir === 1'b1 && dirUp === 1'b0 && fall_at < 0) fall_at = i;
         prev_dir = dirUp;
         total++;
         if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
            bad++;
            $display("FAIL breathe cyc=%0d got=%b/%0d/%b want=%b/%0d/%b",
                     i, led, level, dirUp, e_led, e_level, e_dir);
         end
      end
      // level reaches MAX at step MAX, direction flips on the following step
      total++;
      if (fall_at !== (LMAX + 1) * SD) begin
         bad++;
         $display("FAIL breathe_dir_fall got=%0d want=%0d", fall_at, (LMAX + 1) * SD);
      end
   endtask

   task automatic test_blink;
      step(2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         step(2'b11, (i % 100) == 99, 1'b0);
         total++;
         if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
            bad++;
            $display("FAIL blink cyc=%0d got=%b/%0d/%b want=%b/%0d/%b",
                     i, led, level, dirUp, e_led, e_level, e_dir);
         end
      end
   endtask

   task automatic test_mode_entry;
      step(2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) step(2'b10, 1'b0, 1'b0);
      total++;
      if (level !== PB'(7)) begin
         bad++;
         $display("FAIL entry_pre_level got=%0d want=7", level);
      end
      step(2'b01, 1'b0, 1'b0);
      total++;
      if ({level, dirUp} !== {PB'(0), 1'b1}) begin
         bad++;
         $display("FAIL entry_rearm got=%0d/%b want=0/1", level, dirUp);
      end
      for (int i = 0; i < 40; i++) begin
         step(2'b10, 1'b0, 1'b0);
         total++;
         if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
            bad++;
            $display("FAIL entry_restart cyc=%0d got=%b/%0d/%b want=%b/%0d/%b",
                     i, led, level, dirUp, e_led, e_level, e_dir);
         end
      end
      for (int i = 0; i < 37; i++) step(2'b01, 1'b0, 1'b0);
      total++;
      if (led !== 1'b1) begin
         bad++;
         $display("FAIL midframe_pre_led got=%b want=1", led);
      end
      step(2'b01, 1'b0, 1'b1);
      total++;
      if ({led, level, dirUp} !== {1'b0, PB'(0), 1'b1}) begin
         bad++;
         $display("FAIL midframe_reset got=%b/%0d/%b want=0/0/1", led, level, dirUp);
      end
      for (int i = 0; i < 40; i++) begin
         step(2'b01, 1'b0, 1'b0);
         total++;
         if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
            bad++;
            $display("FAIL after_reset_frame cyc=%0d got=%b/%0d/%b want=%b/%0d/%b",
                     i, led, level, dirUp, e_led, e_level, e_dir);
         end
      end
   endtask

   task automatic test_random;
      logic [1:0] md;
      int         len;
      step(2'b00, 1'b0, 1'b1);
      for (int s = 0; s < 60; s++) begin
         md  = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 150);
         for (int i = 0; i < len; i++) begin
            step(md, ($urandom_range(0, 7) == 0), ($urandom_range(0, 499) == 0));
            total++;
            if ({led, level, dirUp} !== {e_led, e_level, e_dir}) begin
               bad++;
               $display("FAIL random seg=%0d mode=%0d got=%b/%0d/%b want=%b/%0d/%b",
                        s, md, led, level, dirUp, e_led, e_level, e_dir);
            end
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      mode = 2'b00;
      tick = 1'b0;
      test_reset();
      test_on();
      test_breathe();
      test_blink();
      test_mode_entry();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
